// File: rtl/bip_host_pkg.sv
// Shared constants for the BIP host link: command opcodes, response bytes
// and the engine state encoding.
package bip_host_pkg;

    localparam logic [7:0] OP_RUN   = 8'h01;
    localparam logic [7:0] OP_WR_PM = 8'h02;
    localparam logic [7:0] OP_WR_DM = 8'h03;
    localparam logic [7:0] OP_RD_DM = 8'h04;
    localparam logic [7:0] OP_TRACE = 8'h05;

    localparam logic [7:0] ACK_BYTE = 8'hAA;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_GET_ADDR = 4'd1;
    localparam state_t S_GET_CNT  = 4'd2;
    localparam state_t S_GET_DATA = 4'd3;
    localparam state_t S_WRITE    = 4'd4;
    localparam state_t S_RD_REQ   = 4'd5;
    localparam state_t S_RD_WAIT  = 4'd6;
    localparam state_t S_SEND     = 4'd7;
    localparam state_t S_TX_WAIT  = 4'd8;
    localparam state_t S_RUN      = 4'd9;
    localparam state_t S_RESP     = 4'd10;

    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/bip_tx_serializer.sv
// Sends a loaded word as a sequence of bytes, LSB first, one per
// tx_start/tx_done handshake; done_o pulses when the last byte completes.
module bip_tx_serializer #(
    parameter int BYTES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_i,
    input  logic [BYTES*8-1:0]           word_i,
    input  logic [$clog2(BYTES+1)-1:0]   nbytes_i,
    input  logic                         tx_done_i,
    output logic                         tx_start_o,
    output logic [7:0]                   tx_data_o,
    output logic                         done_o
);
    localparam int NBW = $clog2(BYTES + 1);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_SEND = 2'd1;
    localparam logic [1:0] PH_WAIT = 2'd2;

    logic [1:0]         phase_q, phase_d;
    logic [BYTES*8-1:0] shift_q, shift_d;
    logic [NBW-1:0]     left_q, left_d;

    always_comb begin
        phase_d = phase_q;
        shift_d = shift_q;
        left_d  = left_q;
        done_o  = 1'b0;
        case (phase_q)
            PH_SEND: phase_d = PH_WAIT;
            PH_WAIT: begin
                if (tx_done_i) begin
                    if (left_q == NBW'(1)) begin
                        done_o  = 1'b1;
                        phase_d = PH_IDLE;
                    end else begin
                        shift_d = shift_q >> 8;
                        left_d  = left_q - 1'b1;
                        phase_d = PH_SEND;
                    end
                end
            end
            default: ;
        endcase
        if (load_i) begin
            shift_d = word_i;
            left_d  = nbytes_i;
            phase_d = PH_SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            shift_q <= '0;
            left_q  <= '0;
        end else begin
            phase_q <= phase_d;
            shift_q <= shift_d;
            left_q  <= left_d;
        end
    end

    assign tx_start_o = (phase_q == PH_SEND);
    assign tx_data_o  = shift_q[7:0];

endmodule

// File: rtl/bip_host_link.sv
// UART command engine for the BIP: decodes host frames, drives program/data
// memory strobes and BIP reset, and answers through the byte serializer.
module bip_host_link
    import bip_host_pkg::*;
#(
    parameter int DATA_LENGTH    = 16,
    parameter int ADDR_LENGTH    = 11,
    parameter int RUN_CYCLES     = 256,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_done,
    input  logic                   tx_done,
    input  logic [DATA_LENGTH-1:0] in_data,
    input  logic [DATA_LENGTH-1:0] in_acc,
    input  logic [DATA_LENGTH-1:0] in_pc,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   wr_pm,
    output logic                   wr_dm,
    output logic                   rd_dm,
    output logic                   reset_bip,
    output logic [ADDR_LENGTH-1:0] out_addr,
    output logic [DATA_LENGTH-1:0] out_data,
    output logic                   busy
);
    localparam int DB   = bytes_for(DATA_LENGTH);
    localparam int AB   = bytes_for(ADDR_LENGTH);
    localparam int DB8  = DB * 8;
    localparam int AB8  = AB * 8;
    localparam int SW   = 2 * DB8;
    localparam int NBW  = $clog2(2 * DB + 1);
    localparam int CMAX = (RUN_CYCLES > READ_LATENCY) ? RUN_CYCLES : READ_LATENCY;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    state_t         state_q, state_d;
    logic [7:0]     op_q, op_d;
    logic [7:0]     resp_q, resp_d;
    logic [AB8-1:0] addr_q, addr_d;
    logic [DB8-1:0] data_q, data_d;
    logic [7:0]     bcnt_q, bcnt_d;
    logic [8:0]     wcnt_q, wcnt_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [TW-1:0]  tmo_q, tmo_d;

    logic           ser_load, ser_done;
    logic [SW-1:0]  ser_word;
    logic [NBW-1:0] ser_nbytes;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        resp_d     = resp_q;
        addr_d     = addr_q;
        data_d     = data_q;
        bcnt_d     = bcnt_q;
        wcnt_d     = wcnt_q;
        cyc_d      = cyc_q;
        tmo_d      = '0;
        ser_load   = 1'b0;
        ser_word   = '0;
        ser_nbytes = '0;
        case (state_q)
            S_IDLE: begin
                if (rx_done) begin
                    op_d   = rx_data;
                    bcnt_d = '0;
                    cyc_d  = '0;
                    case (rx_data)
                        OP_RUN: state_d = S_RUN;
                        OP_WR_PM, OP_WR_DM, OP_RD_DM: state_d = S_GET_ADDR;
                        OP_TRACE: begin
                            ser_load   = 1'b1;
                            ser_word   = {DB8'(in_pc), DB8'(in_acc)};
                            ser_nbytes = NBW'(2 * DB);
                            state_d    = S_SEND;
                        end
                        default: begin
                            resp_d  = ERR_BYTE;
                            state_d = S_RESP;
                        end
                    endcase
                end
            end
            S_GET_ADDR: begin
                if (rx_done) begin
                    addr_d = (addr_q >> 8) | (AB8'(rx_data) << (AB8 - 8));
                    if (bcnt_q == 8'(AB - 1)) begin
                        bcnt_d  = '0;
                        state_d = S_GET_CNT;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            S_GET_CNT: begin
                if (rx_done) begin
                    wcnt_d  = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    bcnt_d  = '0;
                    cyc_d   = '0;
                    state_d = (op_q == OP_RD_DM) ? S_RD_REQ : S_GET_DATA;
                end
            end
            S_GET_DATA: begin
                if (rx_done) begin
                    data_d = (data_q >> 8) | (DB8'(rx_data) << (DB8 - 8));
                    if (bcnt_q == 8'(DB - 1)) begin
                        bcnt_d  = '0;
                        state_d = S_WRITE;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                addr_d = AB8'(addr_q[ADDR_LENGTH-1:0] + 1'b1);
                wcnt_d = wcnt_q - 1'b1;
                if (wcnt_q == 9'd1) begin
                    resp_d  = ACK_BYTE;
                    state_d = S_RESP;
                end else begin
                    state_d = S_GET_DATA;
                end
            end
            S_RD_REQ: begin
                cyc_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (cyc_q == CW'(READ_LATENCY - 1)) begin
                    ser_load   = 1'b1;
                    ser_word   = SW'(in_data);
                    ser_nbytes = NBW'(DB);
                    state_d    = S_SEND;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_SEND: state_d = S_TX_WAIT;
            S_TX_WAIT: begin
                // op_q is cleared by RESP, so only a live read burst continues here
                if (ser_done) begin
                    if (op_q == OP_RD_DM) begin
                        addr_d = AB8'(addr_q[ADDR_LENGTH-1:0] + 1'b1);
                        wcnt_d = wcnt_q - 1'b1;
                        cyc_d  = '0;
                        state_d = (wcnt_q == 9'd1) ? S_IDLE : S_RD_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                if (cyc_q == CW'(RUN_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_RESP: begin
                ser_load   = 1'b1;
                ser_word   = SW'(resp_q);
                ser_nbytes = NBW'(1);
                op_d       = '0;
                state_d    = S_SEND;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q inside {S_GET_ADDR, S_GET_CNT, S_GET_DATA}) && !rx_done) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                resp_d  = ERR_BYTE;
                state_d = S_RESP;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            resp_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            cyc_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            resp_q  <= resp_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            cyc_q   <= cyc_d;
            tmo_q   <= tmo_d;
        end
    end

    bip_tx_serializer #(
        .BYTES(2 * DB)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load_i    (ser_load),
        .word_i    (ser_word),
        .nbytes_i  (ser_nbytes),
        .tx_done_i (tx_done),
        .tx_start_o(tx_start),
        .tx_data_o (tx_data),
        .done_o    (ser_done)
    );

    assign wr_pm     = (state_q == S_WRITE) && (op_q == OP_WR_PM);
    assign wr_dm     = (state_q == S_WRITE) && (op_q == OP_WR_DM);
    assign rd_dm     = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
    assign reset_bip = (state_q != S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign out_addr  = addr_q[ADDR_LENGTH-1:0];
    assign out_data  = data_q[DATA_LENGTH-1:0];

endmodule

// File: tb/tb_bip_host_link.sv
// Directed bench for bip_host_link: frame table plus hand-written RD, RUN,
// timeout and mid-burst reset sequences against a tx_done responder and memory model.
module tb_bip_host_link;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;
    logic        tx_done = 1'b0;
    logic [15:0] in_data;
    logic [15:0] in_acc = '0;
    logic [15:0] in_pc = '0;
    logic        tx_start, wr_pm, wr_dm, rd_dm, reset_bip, busy;
    logic [7:0]  tx_data;
    logic [10:0] out_addr;
    logic [15:0] out_data;

    always #5 clk = ~clk;

    bip_host_link #(
        .DATA_LENGTH   (16),
        .ADDR_LENGTH   (11),
        .RUN_CYCLES    (256),
        .READ_LATENCY  (1),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .tx_done  (tx_done),
        .in_data  (in_data),
        .in_acc   (in_acc),
        .in_pc    (in_pc),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .wr_pm    (wr_pm),
        .wr_dm    (wr_dm),
        .rd_dm    (rd_dm),
        .reset_bip(reset_bip),
        .out_addr (out_addr),
        .out_data (out_data),
        .busy     (busy)
    );

    // Memory model: word valid only once rd_dm has been high for READ_LATENCY cycles.
    int unsigned rd_age = 0;
    always @(posedge clk) begin
        if (reset || !rd_dm) rd_age <= 0;
        else rd_age <= rd_age + 1;
    end
    assign in_data = (rd_age >= 1) ? {5'b10100, out_addr} : 16'hDEAD;

    typedef struct packed {
        logic        pm;
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wr_log[$];
    logic [7:0]  tx_log[$];
    int unsigned tx_cyc[$];
    logic [10:0] rd_addr[$];
    int unsigned rd_cyc[$];
    int unsigned cyc = 0;
    int unsigned rd_hi = 0;
    int          tx_cd = 0;
    int          proto_err = 0;
    logic        rd_prev = 1'b0;

    always @(negedge clk) begin
        wr_t w;
        cyc++;
        if (!reset) begin
            if (wr_pm || wr_dm) begin
                w.pm = wr_pm; w.addr = out_addr; w.data = out_data;
                wr_log.push_back(w);
            end
            if (rd_dm) rd_hi++;
            if (rd_dm && !rd_prev) begin
                rd_addr.push_back(out_addr);
                rd_cyc.push_back(cyc);
            end
        end
        rd_prev = rd_dm;
        tx_done = 1'b0;
        if (reset) begin
            tx_cd = 0;
        end else begin
            if (tx_start) begin
                if (tx_cd != 0) proto_err++;
                tx_log.push_back(tx_data);
                tx_cyc.push_back(cyc);
            end
            if (tx_cd != 0) begin
                tx_cd--;
                if (tx_cd == 0) tx_done = 1'b1;
            end
            if (tx_start) tx_cd = 3;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_log.delete(); tx_log.delete(); tx_cyc.delete();
        rd_addr.delete(); rd_cyc.delete(); rd_hi = 0;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        idle(5);
        check({name, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " tx_start"},  {31'd0, tx_start},  32'd0);
        check({name, " tx_data"},   {24'd0, tx_data},   32'd0);
        check({name, " wr_pm"},     {31'd0, wr_pm},     32'd0);
        check({name, " wr_dm"},     {31'd0, wr_dm},     32'd0);
        check({name, " rd_dm"},     {31'd0, rd_dm},     32'd0);
        check({name, " reset_bip"}, {31'd0, reset_bip}, 32'd1);
        check({name, " out_addr"},  {21'd0, out_addr},  32'd0);
        check({name, " out_data"},  {16'd0, out_data},  32'd0);
        check({name, " busy"},      {31'd0, busy},      32'd0);
    endtask

    typedef struct packed {
        logic [63:0] bytes;
        logic [3:0]  nbytes;
        logic [15:0] acc;
        logic [15:0] pc;
        logic [2:0]  ntx;
        logic [31:0] tx;
        logic [1:0]  nwr;
        logic        pm;
        logic [10:0] wa0;
        logic [15:0] wd0;
        logic [10:0] wa1;
        logic [15:0] wd1;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    initial begin
        int lowcnt;
        int k;

        // byte k of a frame sits at bytes[8k+:8]; tx byte k at tx[8k+:8]
        vecs[0] = '{bytes:64'hABCD_1234_0200_1003, nbytes:4'd8, acc:16'h0, pc:16'h0,
                    ntx:3'd1, tx:32'h0000_00AA, nwr:2'd2, pm:1'b0,
                    wa0:11'h010, wd0:16'h1234, wa1:11'h011, wd1:16'hABCD};
        vecs[1] = '{bytes:64'h0001_5A5A_02FF_FF02, nbytes:4'd8, acc:16'h0, pc:16'h0,
                    ntx:3'd1, tx:32'h0000_00AA, nwr:2'd2, pm:1'b1,
                    wa0:11'h7FF, wd0:16'h5A5A, wa1:11'h000, wd1:16'h0001};
        vecs[2] = '{bytes:64'h05, nbytes:4'd1, acc:16'h00FE, pc:16'h0123,
                    ntx:3'd4, tx:32'h0123_00FE, nwr:2'd0, pm:1'b0,
                    wa0:11'h0, wd0:16'h0, wa1:11'h0, wd1:16'h0};
        vecs[3] = '{bytes:64'h7F, nbytes:4'd1, acc:16'h0, pc:16'h0,
                    ntx:3'd1, tx:32'h0000_00EE, nwr:2'd0, pm:1'b0,
                    wa0:11'h0, wd0:16'h0, wa1:11'h0, wd1:16'h0};
        vecs[4] = '{bytes:64'h00, nbytes:4'd1, acc:16'h0, pc:16'h0,
                    ntx:3'd1, tx:32'h0000_00EE, nwr:2'd0, pm:1'b0,
                    wa0:11'h0, wd0:16'h0, wa1:11'h0, wd1:16'h0};
        vecs[5] = '{bytes:64'h05, nbytes:4'd1, acc:16'hFFFF, pc:16'h8000,
                    ntx:3'd4, tx:32'h8000_FFFF, nwr:2'd0, pm:1'b0,
                    wa0:11'h0, wd0:16'h0, wa1:11'h0, wd1:16'h0};
        vecs[6] = '{bytes:64'h0000_BEEF_0101_2303, nbytes:4'd6, acc:16'h0, pc:16'h0,
                    ntx:3'd1, tx:32'h0000_00AA, nwr:2'd1, pm:1'b0,
                    wa0:11'h123, wd0:16'hBEEF, wa1:11'h0, wd1:16'h0};

        idle(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(2);

        for (int v = 0; v < NV; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            clear_logs();
            in_acc = vecs[v].acc;
            in_pc  = vecs[v].pc;
            for (int b = 0; b < int'(vecs[v].nbytes); b++) begin
                send_byte(vecs[v].bytes[8*b +: 8]);
                idle(2);
            end
            wait_tx(int'(vecs[v].ntx), 200);
            wait_idle(nm, 50);
            check({nm, " tx count"}, tx_log.size(), {29'd0, vecs[v].ntx});
            for (int b = 0; b < int'(vecs[v].ntx) && b < tx_log.size(); b++)
                check($sformatf("%s tx%0d", nm, b), {24'd0, tx_log[b]}, {24'd0, vecs[v].tx[8*b +: 8]});
            check({nm, " wr count"}, wr_log.size(), {30'd0, vecs[v].nwr});
            if (vecs[v].nwr >= 1 && wr_log.size() >= 1)
                check({nm, " wr0"}, {4'd0, wr_log[0]}, {4'd0, vecs[v].pm, vecs[v].wa0, vecs[v].wd0});
            if (vecs[v].nwr >= 2 && wr_log.size() >= 2)
                check({nm, " wr1"}, {4'd0, wr_log[1]}, {4'd0, vecs[v].pm, vecs[v].wa1, vecs[v].wd1});
        end

        // Burst read across the top of the address space.
        clear_logs();
        send_byte(8'h04); send_byte(8'hFF); send_byte(8'h07); send_byte(8'h02);
        wait_tx(4, 300);
        wait_idle("rd", 50);
        check("rd tx count", tx_log.size(), 32'd4);
        if (tx_log.size() >= 4) begin
            check("rd tx0", {24'd0, tx_log[0]}, 32'hFF);
            check("rd tx1", {24'd0, tx_log[1]}, 32'hA7);
            check("rd tx2", {24'd0, tx_log[2]}, 32'h00);
            check("rd tx3", {24'd0, tx_log[3]}, 32'hA0);
        end
        check("rd req count", rd_addr.size(), 32'd2);
        if (rd_addr.size() >= 2) begin
            check("rd addr0", {21'd0, rd_addr[0]}, 32'h7FF);
            check("rd addr1", {21'd0, rd_addr[1]}, 32'h000);
        end
        check("rd_dm high cycles", rd_hi, 32'd4);
        if (rd_cyc.size() >= 1 && tx_cyc.size() >= 1)
            check("rd to first tx", tx_cyc[0] - rd_cyc[0], 32'd2);
        check("tx handshake", proto_err, 32'd0);

        // RUN: BIP released for exactly 256 cycles.
        clear_logs();
        send_byte(8'h01);
        check("run reset_bip low", {31'd0, reset_bip}, 32'd0);
        check("run busy", {31'd0, busy}, 32'd1);
        lowcnt = 0;
        while (reset_bip == 1'b0 && lowcnt < 400) begin
            lowcnt++;
            @(negedge clk);
        end
        check("run low cycles", lowcnt, 32'd256);
        check("run busy after", {31'd0, busy}, 32'd0);
        check("run no tx", tx_log.size(), 32'd0);

        // Timeout: a gap just under the limit survives, a full one aborts.
        clear_logs();
        send_byte(8'h02);
        idle(TMO - 3);
        check("tmo short gap busy", {31'd0, busy}, 32'd1);
        check("tmo short gap no tx", tx_log.size(), 32'd0);
        send_byte(8'h10);
        send_byte(8'h00);
        k = 0;
        while (tx_start !== 1'b1 && k < TMO + 20) begin
            @(negedge clk);
            k++;
        end
        check("tmo delay", k, TMO + 1);
        check("tmo err byte", {24'd0, tx_data}, 32'hEE);
        wait_idle("tmo", 50);
        check("tmo no write", wr_log.size(), 32'd0);
        check("tmo tx count", tx_log.size(), 32'd1);

        // Reset in the middle of a 256-word read burst.
        clear_logs();
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_tx(3, 300);
        check("burst started", {31'd0, tx_log.size() >= 3}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        clear_logs();
        idle(10);
        check("midreset silent", tx_log.size(), 32'd0);
        check("midreset idle", {31'd0, busy}, 32'd0);
        in_acc = 16'h1234;
        in_pc  = 16'h5678;
        send_byte(8'h05);
        wait_tx(4, 100);
        wait_idle("post trace", 50);
        check("post trace count", tx_log.size(), 32'd4);
        if (tx_log.size() >= 4)
            check("post trace bytes", {tx_log[3], tx_log[2], tx_log[1], tx_log[0]}, 32'h5678_1234);
        check("final handshake", proto_err, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/bip_host_link.md
# bip_host_link

Host-side UART command engine for the BIP processor. It sits between the UART byte receiver/transmitter pair and the BIP core plus its program and data memories. It decodes framed host commands (run, burst program/data write, burst data read, register trace) and drives memory strobes and processor reset. It is the parametrised successor of the single-word loader: configurable widths, burst transfers with address auto-increment, acknowledge/error responses and an inter-byte receive timeout.

## Interface
- DATA_LENGTH, 16, memory/register word width; DATA_BYTES = ceil(DATA_LENGTH/8)
- ADDR_LENGTH, 11, memory address width; ADDR_BYTES = ceil(ADDR_LENGTH/8)
- RUN_CYCLES, 256, cycles reset_bip is held low per RUN command (≥1)
- READ_LATENCY, 1, cycles from rd_dm rising to in_data valid (≥1)
- TIMEOUT_CYCLES, 65535, idle cycles allowed between bytes inside a frame
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rx_data  in  8  received byte, valid with rx_done
- rx_done  in  1  one-cycle pulse per received byte
- tx_done  in  1  one-cycle pulse when transmitter finishes a byte
- in_data  in  DATA_LENGTH  data memory read word
- in_acc  in  DATA_LENGTH  BIP accumulator
- in_pc  in  DATA_LENGTH  BIP program counter
- tx_start  out  1  one-cycle pulse, launch tx_data
- tx_data  out  8  byte to transmit
- wr_pm  out  1  program memory write strobe (one cycle)
- wr_dm  out  1  data memory write strobe (one cycle)
- rd_dm  out  1  data memory read enable
- reset_bip  out  1  1 = BIP held in reset, 0 = running
- out_addr  out  ADDR_LENGTH  memory address
- out_data  out  DATA_LENGTH  memory write word
- busy  out  1  high in every state except IDLE

## Operation
- Reset values: all strobes 0, tx_data 0, out_addr 0, out_data 0, reset_bip 1, busy 0, state IDLE.
- Frame: opcode, then ADDR_BYTES address bytes LSB first, then count byte N (words = N, N=0 means 256), then payload. All multi-byte fields LSB first; excess high address/data bits are discarded.
- Opcodes: 0x01 RUN (no fields), 0x02 WR_PM, 0x03 WR_DM, 0x04 RD_DM, 0x05 TRACE (no fields). Any other opcode: transmit 0xEE, return IDLE.
- States: IDLE, GET_ADDR, GET_CNT, GET_DATA, WRITE, RD_REQ, RD_WAIT, SEND, TX_WAIT, RUN, RESP.
- WR_PM/WR_DM: GET_DATA collects DATA_BYTES per word, then WRITE pulses the strobe. out_addr increments by 1 after each write and wraps modulo 2^ADDR_LENGTH. After the last word, RESP sends 0xAA.
- RD_DM: per word, RD_REQ raises rd_dm and RD_WAIT waits READ_LATENCY cycles, then latches in_data into a shift register and drops rd_dm. SEND/TX_WAIT emits DATA_BYTES bytes. The address increments and the engine repeats for N words. There is no trailing ack.
- TRACE: latches in_acc and in_pc in the same cycle, then sends in_acc bytes followed by in_pc bytes (2·DATA_BYTES bytes).
- RUN: reset_bip = 0 for exactly RUN_CYCLES cycles, then 1; return IDLE. reset_bip is 1 in all other states.
- Timeout: in GET_ADDR/GET_CNT/GET_DATA, a counter clears on each rx_done. Reaching TIMEOUT_CYCLES aborts the frame (no strobe), sends 0xEE and returns to IDLE.
- rx_done outside IDLE/GET_* states is dropped. tx_done outside TX_WAIT is ignored.
- reset mid-frame: immediate return to reset values. Any partial write or transmit is abandoned.

## Timing
- rx_done of last byte of a word at cycle t: out_data valid and wr_* = 1 at t+1 only; out_addr stable across t+1, incremented at t+2.
- tx_start high one cycle with tx_data valid that same cycle. The next tx_start comes no earlier than the cycle after tx_done.
- RD: rd_dm high from cycle r to r+READ_LATENCY; in_data sampled at r+READ_LATENCY; first tx_start at r+READ_LATENCY+1.
- Opcode in IDLE at t: busy = 1 from t+1. RUN: reset_bip low t+1 … t+RUN_CYCLES.

## Structure
- Package bip_host_pkg: opcode constants, ACK (0xAA) and ERR (0xEE) bytes, state enumeration.
- Sub-module bip_tx_serializer: loads a word of N bytes, issues tx_start/tx_data per byte, waits on tx_done and signals done. Shared by read, trace and response paths.

## Test plan
- Opcode 0x03, addr 0x0010, N=2, data 0x1234, 0xABCD -> wr_dm pulses at addr 0x010 with 0x1234 and at 0x011 with 0xABCD, then tx byte 0xAA.
- Opcode 0x04, addr 0x07FF, N=2, memory model returns addr-based words -> rd_dm at 0x7FF then 0x000 (wrap); 4 bytes sent LSB first, each after tx_done.
- Opcode 0x05 with in_acc = 0x00FE, in_pc = 0x0123 -> bytes FE 00 23 01.
- Opcode 0x01 -> reset_bip low for exactly 256 cycles, busy back to 0 the cycle after.
- Opcode 0x02, address bytes sent, then silence for TIMEOUT_CYCLES -> no wr_pm, tx 0xEE, IDLE. Opcode 0x7F -> tx 0xEE.
- reset asserted during a RD_DM burst -> next cycle all outputs at reset values; a following 0x05 frame behaves normally.
